// File: rtl/cpu_sequencer_if.sv
// Memory-side bus of the instruction sequencer: one request/ready handshake
// shared by instruction fetch and LOAD/STORE data accesses.
interface cpu_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        instr_in;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr,
    input  instr_in, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    output instr_in, mem_ready
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit CPU.
// Owns PC and IR and drives the ALU, register-file and memory strobes.
module cpu_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  cpu_sequencer_if.master    bus,
  output logic [1:0]         alu_op,
  output logic               reg_write,
  output logic [7:0]         ir,
  output logic [ADDR_W-1:0]  pc,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               bus_err,
  output logic [15:0]        retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_LOAD  = 4'b0110;
  localparam logic [3:0] OP_STORE = 4'b0111;
  localparam logic [3:0] OP_JUMP  = 4'b1111;

  // The last tolerated wait cycle is the one where the counter sits at TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_cnt;
  logic       retire;
  logic       timeout_hit;
  logic       wait_expired;
  logic [3:0] opcode;
  state_t     boundary;

  assign opcode       = ir[7:4];
  assign state        = state_q;
  assign boundary     = run ? S_FETCH : S_IDLE;
  assign wait_expired = !bus.mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE:
        if (run && !bus_err) state_d = S_FETCH;
      S_FETCH:
        if (bus.mem_ready) state_d = S_DECODE;
        else if (wait_expired) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      S_DECODE:
        case (opcode)
          OP_ADD, OP_SUB:    state_d = S_EXEC;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_JUMP: begin
            retire  = 1'b1;
            state_d = boundary;
          end
          default:           state_d = boundary;
        endcase
      S_EXEC: begin
        retire  = 1'b1;
        state_d = boundary;
      end
      S_MEM:
        if (bus.mem_ready) begin
          if (opcode == OP_STORE) begin
            retire  = 1'b1;
            state_d = boundary;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      S_WB: begin
        retire  = 1'b1;
        state_d = boundary;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The wait counter restarts whenever the FSM changes state, so every
  // FETCH or MEM visit gets a fresh timeout budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      ir       <= 8'h00;
      retired  <= 16'h0000;
      bus_err  <= 1'b0;
      wait_cnt <= 8'h00;
    end else begin
      if (state_q == S_FETCH && bus.mem_ready) begin
        ir <= bus.instr_in;
        pc <= pc + ADDR_W'(1);
      end
      if (state_q == S_DECODE && opcode == OP_JUMP)
        pc <= ADDR_W'(ir[3:0]);
      if (retire)
        retired <= retired + 16'd1;
      if (timeout_hit)
        bus_err <= 1'b1;
      if (state_d != state_q)
        wait_cnt <= 8'h00;
      else if (bus.mem_req && !bus.mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    alu_op       = 2'b00;
    reg_write    = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = pc;
      end
      S_DECODE:
        illegal = !(opcode == OP_ADD  || opcode == OP_SUB   ||
                    opcode == OP_LOAD || opcode == OP_STORE ||
                    opcode == OP_JUMP);
      S_EXEC: begin
        reg_write = 1'b1;
        alu_op    = (opcode == OP_SUB) ? 2'b01 : 2'b00;
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = ADDR_W'(ir[3:0]);
        bus.mem_we   = (opcode == OP_STORE);
        alu_op       = (opcode == OP_STORE) ? 2'b11 : 2'b10;
      end
      S_WB: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a small memory model feeds a fixed program
// and every observed output is compared against hand-computed values.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic [7:0]  ir;
  logic [7:0]  pc;
  logic [2:0]  state;
  logic        illegal;
  logic        bus_err;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  int         fetch_wait;
  int         data_wait;
  logic       stall;
  logic       found;

  cpu_sequencer_if #(.ADDR_W(8)) bus ();

  cpu_sequencer #(.ADDR_W(8), .RESET_PC(8'h00), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .bus       (bus),
    .alu_op    (alu_op),
    .reg_write (reg_write),
    .ir        (ir),
    .pc        (pc),
    .state     (state),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic run_v, input logic rst_v);
    run   = run_v;
    rst_n = rst_v;
  endtask

  // Memory model acts just after each falling edge, answering fetches after
  // fetch_wait idle cycles and data accesses after data_wait idle cycles.
  initial begin
    int waited;
    int limit;
    waited        = 0;
    bus.mem_ready = 1'b0;
    bus.instr_in  = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (bus.mem_req) begin
        limit = (state == 3'd4) ? data_wait : fetch_wait;
        if (!stall && waited >= limit) begin
          bus.mem_ready = 1'b1;
          bus.instr_in  = mem[bus.mem_addr];
          waited        = 0;
        end else begin
          bus.mem_ready = 1'b0;
          waited++;
        end
      end else begin
        bus.mem_ready = 1'b0;
        waited        = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0]   = 8'h13;
    mem[1]   = 8'h65;
    mem[2]   = 8'h7A;
    mem[3]   = 8'h50;
    mem[4]   = 8'h21;
    mem[5]   = 8'h14;
    mem[255] = 8'hF3;
    fetch_wait = 0;
    data_wait  = 0;
    stall      = 1'b0;
    found      = 1'b0;

    applyStimulus(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_state", state, 3'd0);
    checkOutput("rst_pc", pc, 8'h00);
    checkOutput("rst_ir", ir, 8'h00);
    checkOutput("rst_retired", retired, 16'd0);
    checkOutput("rst_bus_err", bus_err, 1'b0);
    checkOutput("rst_mem_req", bus.mem_req, 1'b0);
    checkOutput("rst_reg_write", reg_write, 1'b0);
    checkOutput("rst_alu_op", alu_op, 2'b00);
    applyStimulus(1'b1, 1'b1);

    // ADD 0x13 at address 0
    @(negedge clk);
    checkOutput("add_fetch_state", state, 3'd1);
    checkOutput("add_fetch_req", bus.mem_req, 1'b1);
    checkOutput("add_fetch_addr", bus.mem_addr, 8'h00);
    checkOutput("add_fetch_we", bus.mem_we, 1'b0);
    @(negedge clk);
    checkOutput("add_dec_state", state, 3'd2);
    checkOutput("add_dec_pc", pc, 8'h01);
    checkOutput("add_dec_ir", ir, 8'h13);
    checkOutput("add_dec_rw", reg_write, 1'b0);
    @(negedge clk);
    checkOutput("add_exec_state", state, 3'd3);
    checkOutput("add_exec_rw", reg_write, 1'b1);
    checkOutput("add_exec_alu", alu_op, 2'b00);
    checkOutput("add_exec_retired", retired, 16'd0);
    @(negedge clk);
    checkOutput("add_next_state", state, 3'd1);
    checkOutput("add_next_addr", bus.mem_addr, 8'h01);
    checkOutput("add_retired", retired, 16'd1);
    checkOutput("add_next_rw", reg_write, 1'b0);

    // LOAD 0x65 with three data wait cycles
    data_wait = 3;
    @(negedge clk);
    checkOutput("ld_dec_state", state, 3'd2);
    checkOutput("ld_dec_ir", ir, 8'h65);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("ld_mem_state", state, 3'd4);
      checkOutput("ld_mem_addr", bus.mem_addr, 8'h05);
      checkOutput("ld_mem_we", bus.mem_we, 1'b0);
      checkOutput("ld_mem_alu", alu_op, 2'b10);
      checkOutput("ld_mem_rw", reg_write, 1'b0);
    end
    @(negedge clk);
    checkOutput("ld_wb_state", state, 3'd5);
    checkOutput("ld_wb_rw", reg_write, 1'b1);
    checkOutput("ld_wb_alu", alu_op, 2'b10);
    checkOutput("ld_wb_retired", retired, 16'd1);
    @(negedge clk);
    checkOutput("ld_next_state", state, 3'd1);
    checkOutput("ld_next_addr", bus.mem_addr, 8'h02);
    checkOutput("ld_retired", retired, 16'd2);
    data_wait = 0;

    // STORE 0x7A
    @(negedge clk);
    checkOutput("st_dec_ir", ir, 8'h7A);
    @(negedge clk);
    checkOutput("st_mem_state", state, 3'd4);
    checkOutput("st_mem_we", bus.mem_we, 1'b1);
    checkOutput("st_mem_addr", bus.mem_addr, 8'h0A);
    checkOutput("st_mem_alu", alu_op, 2'b11);
    checkOutput("st_mem_rw", reg_write, 1'b0);
    @(negedge clk);
    checkOutput("st_next_state", state, 3'd1);
    checkOutput("st_next_addr", bus.mem_addr, 8'h03);
    checkOutput("st_retired", retired, 16'd3);

    // Undefined opcode 0x50
    @(negedge clk);
    checkOutput("ill_dec_state", state, 3'd2);
    checkOutput("ill_pulse", illegal, 1'b1);
    checkOutput("ill_rw", reg_write, 1'b0);
    checkOutput("ill_we", bus.mem_we, 1'b0);
    @(negedge clk);
    checkOutput("ill_next_state", state, 3'd1);
    checkOutput("ill_pulse_end", illegal, 1'b0);
    checkOutput("ill_next_addr", bus.mem_addr, 8'h04);
    checkOutput("ill_retired", retired, 16'd3);

    // SUB 0x21, then ADD 0x14 with run dropped during EXEC
    @(negedge clk);
    @(negedge clk);
    checkOutput("sub_exec_state", state, 3'd3);
    checkOutput("sub_exec_alu", alu_op, 2'b01);
    checkOutput("sub_exec_rw", reg_write, 1'b1);
    @(negedge clk);
    checkOutput("sub_retired", retired, 16'd4);
    checkOutput("sub_next_addr", bus.mem_addr, 8'h05);
    @(negedge clk);
    @(negedge clk);
    checkOutput("stop_exec_state", state, 3'd3);
    checkOutput("stop_exec_alu", alu_op, 2'b00);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("stop_idle_state", state, 3'd0);
    checkOutput("stop_retired", retired, 16'd5);
    checkOutput("stop_req", bus.mem_req, 1'b0);
    checkOutput("stop_pc", pc, 8'h06);
    @(negedge clk);
    checkOutput("stop_hold_state", state, 3'd0);

    // Walk illegal fillers up to the JUMP at 0xFF
    applyStimulus(1'b1, 1'b1);
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge clk);
      if (state == 3'd1 && bus.mem_addr == 8'hFF) found = 1'b1;
    end
    checkOutput("jmp_reached_ff", found, 1'b1);
    checkOutput("jmp_fetch_pc", pc, 8'hFF);
    @(negedge clk);
    checkOutput("jmp_dec_state", state, 3'd2);
    checkOutput("jmp_wrap_pc", pc, 8'h00);
    checkOutput("jmp_dec_ir", ir, 8'hF3);
    checkOutput("jmp_illegal", illegal, 1'b0);
    @(negedge clk);
    checkOutput("jmp_next_state", state, 3'd1);
    checkOutput("jmp_next_addr", bus.mem_addr, 8'h03);
    checkOutput("jmp_pc", pc, 8'h03);
    checkOutput("jmp_retired", retired, 16'd6);

    // Memory never answers this fetch: 15 wait cycles then bus error
    stall = 1'b1;
    repeat (13) @(negedge clk);
    checkOutput("to_wait14_state", state, 3'd1);
    checkOutput("to_wait14_err", bus_err, 1'b0);
    @(negedge clk);
    checkOutput("to_wait15_state", state, 3'd1);
    checkOutput("to_wait15_req", bus.mem_req, 1'b1);
    checkOutput("to_wait15_err", bus_err, 1'b0);
    @(negedge clk);
    checkOutput("to_idle_state", state, 3'd0);
    checkOutput("to_bus_err", bus_err, 1'b1);
    checkOutput("to_req_drop", bus.mem_req, 1'b0);
    checkOutput("to_pc_kept", pc, 8'h03);
    checkOutput("to_ir_kept", ir, 8'hF3);
    repeat (3) @(negedge clk);
    checkOutput("to_stay_idle", state, 3'd0);
    checkOutput("to_sticky", bus_err, 1'b1);

    applyStimulus(1'b1, 1'b0);
    #1;
    checkOutput("rst2_bus_err", bus_err, 1'b0);
    checkOutput("rst2_pc", pc, 8'h00);
    checkOutput("rst2_state", state, 3'd0);
    checkOutput("rst2_retired", retired, 16'd0);
    stall      = 1'b0;
    fetch_wait = 14;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1);

    // Ready arriving on the 15th wait cycle is still a successful fetch
    @(negedge clk);
    checkOutput("edge_fetch_state", state, 3'd1);
    checkOutput("edge_fetch_addr", bus.mem_addr, 8'h00);
    repeat (14) @(negedge clk);
    checkOutput("edge_wait15_state", state, 3'd1);
    checkOutput("edge_wait15_err", bus_err, 1'b0);
    @(negedge clk);
    checkOutput("edge_dec_state", state, 3'd2);
    checkOutput("edge_dec_ir", ir, 8'h13);
    checkOutput("edge_dec_pc", pc, 8'h01);
    checkOutput("edge_no_err", bus_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
